// File: rtl/ck1_spi_master_if.sv
// ck1_spi_master_if
//   Bundles the SPI pins and the host-side command/status signals of
//   ck1_spi_master.
//   master modport: the SPI master itself. It drives the SPI pins, the
//                   received byte and the ready flag, and it consumes the
//                   host strobes and spi_miso.
//   slave modport : the host/peripheral side, which is the mirror image.
//   Signals:
//     spi_ss, spi_sck, spi_mosi  SPI pins driven by the master
//     spi_miso                   SPI data returned by the device
//     spi_enable/_vld            select request and its strobe
//     spi_start                  start-transfer strobe
//     spi_tx_data/_vld           byte to send and its load strobe
//     spi_rx_data                last received byte
//     spi_ready                  idle flag; a transfer may start when it is 1
interface ck1_spi_master_if;
  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_enable;
  logic       spi_enable_vld;
  logic       spi_start;
  logic [7:0] spi_tx_data;
  logic       spi_tx_data_vld;
  logic [7:0] spi_rx_data;
  logic       spi_ready;

  modport master (
    output spi_ss, spi_sck, spi_mosi, spi_rx_data, spi_ready,
    input  spi_miso, spi_enable, spi_enable_vld, spi_start,
           spi_tx_data, spi_tx_data_vld
  );

  modport slave (
    input  spi_ss, spi_sck, spi_mosi, spi_rx_data, spi_ready,
    output spi_miso, spi_enable, spi_enable_vld, spi_start,
           spi_tx_data, spi_tx_data_vld
  );
endinterface

// File: rtl/ck1_spi_master.sv
// ck1_spi_master
//   Mode-0 SPI master that moves one byte per transfer, MSB first. Each
//   SCK half-period lasts HALF_PERIOD clk cycles. spi_ready is low for
//   exactly 16*HALF_PERIOD+1 cycles per transfer. The received byte is
//   published on the same edge on which spi_ready rises.
//   Ports:
//     clk      system clock; all state changes occur on its rising edge
//     reset_n  asynchronous, active-low reset
//     bus      ck1_spi_master_if.master: SPI pins plus host strobes/status
module ck1_spi_master #(
  parameter int HALF_PERIOD = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ck1_spi_master_if.master       bus
);

  typedef enum logic [1:0] {IDLE, SCK_LOW, SCK_HIGH, DONE} state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_PERIOD - 1);

  state_t     state_reg,    state_next;
  logic [2:0] bit_cnt_reg,  bit_cnt_next;
  logic [7:0] half_cnt_reg, half_cnt_next;
  logic [7:0] tx_buf_reg,   tx_buf_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic [7:0] rx_data_reg,  rx_data_next;
  logic       ss_reg,       ss_next;
  logic       half_done;

  assign half_done = (half_cnt_reg == HALF_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      half_cnt_reg <= 8'd0;
      tx_buf_reg   <= 8'd0;
      tx_shift_reg <= 8'd0;
      rx_shift_reg <= 8'd0;
      rx_data_reg  <= 8'd0;
      ss_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      half_cnt_reg <= half_cnt_next;
      tx_buf_reg   <= tx_buf_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      ss_reg       <= ss_next;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    half_cnt_next = half_cnt_reg;
    tx_buf_next   = tx_buf_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    // Slave select is independent of the transfer state machine.
    ss_next       = bus.spi_enable_vld ? ~bus.spi_enable : ss_reg;

    case (state_reg)
      IDLE: begin
        // The loaded byte lives in tx_buf so that a repeated start resends
        // it, even though the shift register has been consumed.
        if (bus.spi_tx_data_vld) begin
          tx_buf_next = bus.spi_tx_data;
        end
        if (bus.spi_start) begin
          state_next    = SCK_LOW;
          bit_cnt_next  = 3'd0;
          half_cnt_next = 8'd0;
          tx_shift_next = bus.spi_tx_data_vld ? bus.spi_tx_data : tx_buf_reg;
        end
      end
      SCK_LOW: begin
        if (half_done) begin
          half_cnt_next = 8'd0;
          state_next    = SCK_HIGH;
          rx_shift_next = {rx_shift_reg[6:0], bus.spi_miso};
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end
      SCK_HIGH: begin
        if (half_done) begin
          half_cnt_next = 8'd0;
          if (bit_cnt_reg == 3'd7) begin
            state_next = DONE;
          end else begin
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            state_next    = SCK_LOW;
          end
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end
      DONE: begin
        rx_data_next = rx_shift_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs. SCK and ready are decoded from the registered state, so they
  // change on the same edges as the state itself. MOSI is the MSB of the
  // shift register, which only moves while SCK is low and is untouched
  // between transfers, so the last bit is held until the next start.
  always_comb begin
    bus.spi_sck     = (state_reg == SCK_HIGH);
    bus.spi_ready   = (state_reg == IDLE);
    bus.spi_mosi    = tx_shift_reg[7];
    bus.spi_ss      = ss_reg;
    bus.spi_rx_data = rx_data_reg;
  end

endmodule

// File: tb/tb_ck1_spi_master.sv
module tb_ck1_spi_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ck1_spi_master_if b1 ();
  ck1_spi_master_if b4 ();

  ck1_spi_master #(.HALF_PERIOD(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  ck1_spi_master #(.HALF_PERIOD(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

  // Stimulus goes to the DUT chosen by sel; the other one sees idle inputs.
  logic       sel = 1'b0;
  logic       start_v = 1'b0, tx_vld = 1'b0, en_v = 1'b0, en_vld = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] miso_mode = 2'd0;   // 0 loopback, 1 tied high, 2 tied low

  assign b1.spi_start       = start_v & ~sel;
  assign b1.spi_tx_data_vld = tx_vld & ~sel;
  assign b1.spi_enable_vld  = en_vld & ~sel;
  assign b1.spi_enable      = en_v;
  assign b1.spi_tx_data     = tx_data;
  assign b1.spi_miso        = (miso_mode == 2'd0) ? b1.spi_mosi : (miso_mode == 2'd1);
  assign b4.spi_start       = start_v & sel;
  assign b4.spi_tx_data_vld = tx_vld & sel;
  assign b4.spi_enable_vld  = en_vld & sel;
  assign b4.spi_enable      = en_v;
  assign b4.spi_tx_data     = tx_data;
  assign b4.spi_miso        = (miso_mode == 2'd0) ? b4.spi_mosi : (miso_mode == 2'd1);

  logic       rdy, sck, mosi, ss;
  logic [7:0] rx;
  assign rdy  = sel ? b4.spi_ready   : b1.spi_ready;
  assign sck  = sel ? b4.spi_sck     : b1.spi_sck;
  assign mosi = sel ? b4.spi_mosi    : b1.spi_mosi;
  assign ss   = sel ? b4.spi_ss      : b1.spi_ss;
  assign rx   = sel ? b4.spi_rx_data : b1.spi_rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] tx;
    logic [1:0] mode;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
    int         exp_low;
    int         exp_half;
  } vec_t;

  // Runs one transfer on the selected DUT, sampling on falling edges.
  // inj: 0 none, 1 start+load 0x11 at sample 5, 2 deselect at sample 5.
  task automatic run_xfer(input bit load, input logic [7:0] tx, input int inj,
                          output int low_cnt, output int pulses, output logic [7:0] mseq,
                          output int hmin, output int hmax, output int lmin, output int lmax,
                          output int unstable, output int rx_chg);
    logic prev_s, held;
    logic [7:0] rx0;
    int hrun, lrun;
    low_cnt = 0; pulses = 0; mseq = 8'h00; unstable = 0; rx_chg = 0;
    hmin = 9999; hmax = 0; lmin = 9999; lmax = 0;
    prev_s = 1'b0; held = 1'b0; hrun = 0; lrun = 0;
    @(negedge clk);
    if (load) begin
      tx_data = tx;
      tx_vld  = 1'b1;
    end
    start_v = 1'b1;
    rx0 = rx;
    @(negedge clk);
    start_v = 1'b0; tx_vld = 1'b0;
    while (rdy == 1'b0 && low_cnt < 2000) begin
      start_v = 1'b0; tx_vld = 1'b0; en_vld = 1'b0;
      low_cnt++;
      if (rx !== rx0) rx_chg++;
      if (sck && !prev_s) begin
        pulses++;
        mseq = {mseq[6:0], mosi};
        held = mosi;
        if (lrun < lmin) lmin = lrun;
        if (lrun > lmax) lmax = lrun;
        hrun = 1;
      end else if (sck) begin
        hrun++;
        if (mosi !== held) unstable++;
      end else if (prev_s) begin
        if (hrun < hmin) hmin = hrun;
        if (hrun > hmax) hmax = hrun;
        lrun = 1;
      end else begin
        lrun++;
      end
      prev_s = sck;
      if (low_cnt == 5 && inj == 1) begin
        start_v = 1'b1; tx_data = 8'h11; tx_vld = 1'b1;
      end
      if (low_cnt == 5 && inj == 2) begin
        en_v = 1'b0; en_vld = 1'b1;
      end
      @(negedge clk);
    end
    start_v = 1'b0; tx_vld = 1'b0; en_vld = 1'b0;
    if (low_cnt >= 2000) chk("ready_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[6];
  int low_cnt, pulses, hmin, hmax, lmin, lmax, unstable, rx_chg;
  logic [7:0] mseq;

  initial begin
    // sel, tx, miso mode, expected MOSI bits, expected rx, ready-low cycles, half period
    vecs[0] = '{1'b0, 8'hA5, 2'd0, 8'hA5, 8'hA5, 17, 1};
    vecs[1] = '{1'b0, 8'h00, 2'd1, 8'h00, 8'hFF, 17, 1};
    vecs[2] = '{1'b0, 8'h3C, 2'd2, 8'h3C, 8'h00, 17, 1};
    vecs[3] = '{1'b0, 8'hC3, 2'd0, 8'hC3, 8'hC3, 17, 1};
    vecs[4] = '{1'b0, 8'h01, 2'd1, 8'h01, 8'hFF, 17, 1};
    vecs[5] = '{1'b1, 8'h5A, 2'd0, 8'h5A, 8'h5A, 65, 4};

    // Reset state of both DUTs
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("reset_ss", {31'd0, ss}, 32'd1);
      chk("reset_sck", {31'd0, sck}, 32'd0);
      chk("reset_mosi", {31'd0, mosi}, 32'd0);
      chk("reset_ready", {31'd0, rdy}, 32'd1);
      chk("reset_rx", {24'd0, rx}, 32'h00);
    end
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Select the device: ss falls on the next edge
    @(negedge clk);
    en_v = 1'b1; en_vld = 1'b1;
    @(negedge clk);
    en_vld = 1'b0;
    chk("enable_ss_low", {31'd0, ss}, 32'd0);
    $display("[TB] enable=1 -> spi_ss=%0b", ss);

    // Table-driven transfers
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      miso_mode = vecs[i].mode;
      run_xfer(1'b1, vecs[i].tx, 0, low_cnt, pulses, mseq, hmin, hmax, lmin, lmax, unstable, rx_chg);
      chk("ready_low", low_cnt, vecs[i].exp_low);
      chk("sck_pulses", pulses, 32'd8);
      chk("mosi_bits", {24'd0, mseq}, {24'd0, vecs[i].exp_mosi});
      chk("rx_data", {24'd0, rx}, {24'd0, vecs[i].exp_rx});
      chk("high_min", hmin, vecs[i].exp_half);
      chk("high_max", hmax, vecs[i].exp_half);
      chk("low_min", lmin, vecs[i].exp_half);
      chk("low_max", lmax, vecs[i].exp_half);
      chk("mosi_stable", unstable, 32'd0);
      chk("rx_hold", rx_chg, 32'd0);
      $display("[TB] vec %0d hp=%0d tx=%02h mosi=%02h rx=%02h low=%0d pulses=%0d",
               i, vecs[i].exp_half, vecs[i].tx, mseq, rx, low_cnt, pulses);
    end

    // Start and load during a transfer are ignored; the byte is resent
    sel = 1'b0; miso_mode = 2'd0;
    run_xfer(1'b1, 8'h80, 1, low_cnt, pulses, mseq, hmin, hmax, lmin, lmax, unstable, rx_chg);
    chk("ign_rx", {24'd0, rx}, 32'h80);
    chk("ign_mosi", {24'd0, mseq}, 32'h80);
    chk("ign_low", low_cnt, 32'd17);
    $display("[TB] ignore-test tx=80 rx=%02h low=%0d", rx, low_cnt);
    repeat (2) @(negedge clk);
    chk("ign_no_restart", {31'd0, rdy}, 32'd1);
    run_xfer(1'b0, 8'h00, 0, low_cnt, pulses, mseq, hmin, hmax, lmin, lmax, unstable, rx_chg);
    chk("resend_mosi", {24'd0, mseq}, 32'h80);
    chk("resend_rx", {24'd0, rx}, 32'h80);
    $display("[TB] resend mosi=%02h rx=%02h", mseq, rx);

    // Deselect mid-transfer: ss rises, transfer still completes
    chk("pre_desel_ss", {31'd0, ss}, 32'd0);
    run_xfer(1'b1, 8'h81, 2, low_cnt, pulses, mseq, hmin, hmax, lmin, lmax, unstable, rx_chg);
    chk("desel_ss", {31'd0, ss}, 32'd1);
    chk("desel_pulses", pulses, 32'd8);
    chk("desel_rx", {24'd0, rx}, 32'h81);
    $display("[TB] deselect mid-transfer ss=%0b pulses=%0d rx=%02h", ss, pulses, rx);

    // MOSI and rx hold after a transfer, even when a new byte is loaded
    @(negedge clk);
    tx_data = 8'h00; tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("mosi_hold", {31'd0, mosi}, 32'd1);
    chk("rx_hold_idle", {24'd0, rx}, 32'h81);
    $display("[TB] idle hold mosi=%0b rx=%02h", mosi, rx);

    // Asynchronous reset at cycle 9 of a transfer
    @(negedge clk);
    en_v = 1'b1; en_vld = 1'b1;
    @(negedge clk);
    en_vld = 1'b0;
    tx_data = 8'hFF; tx_vld = 1'b1; start_v = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0; start_v = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_sck", {31'd0, sck}, 32'd1);
    chk("pre_rst_mosi", {31'd0, mosi}, 32'd1);
    chk("pre_rst_ss", {31'd0, ss}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_ss", {31'd0, ss}, 32'd1);
    chk("arst_sck", {31'd0, sck}, 32'd0);
    chk("arst_mosi", {31'd0, mosi}, 32'd0);
    chk("arst_ready", {31'd0, rdy}, 32'd1);
    chk("arst_rx", {24'd0, rx}, 32'h00);
    $display("[TB] async reset mid-transfer ss=%0b sck=%0b mosi=%0b ready=%0b rx=%02h",
             ss, sck, mosi, rdy, rx);
    @(negedge clk);
    reset_n = 1'b1;
    run_xfer(1'b1, 8'h96, 0, low_cnt, pulses, mseq, hmin, hmax, lmin, lmax, unstable, rx_chg);
    chk("post_rst_low", low_cnt, 32'd17);
    chk("post_rst_mosi", {24'd0, mseq}, 32'h96);
    chk("post_rst_rx", {24'd0, rx}, 32'h96);
    $display("[TB] post-reset tx=96 mosi=%02h rx=%02h low=%0d", mseq, rx, low_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ck1_spi_master.md
CK1_SPI_MASTER -- requirements
Module: ck1_spi_master

Interface
REQ-001 Parameter: HALF_PERIOD, default 1, number of clk cycles per SCK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 spi_ss  output  1  slave select, active low.
REQ-005 spi_sck  output  1  serial clock, SPI mode 0 (idle low).
REQ-006 spi_mosi  output  1  serial data out, MSB first.
REQ-007 spi_miso  input  1  serial data in, sampled on SCK rising edge.
REQ-008 spi_enable  input  1  requested select state (1 = select device).
REQ-009 spi_enable_vld  input  1  single-cycle strobe; applies spi_enable.
REQ-010 spi_start  input  1  single-cycle strobe; starts one 8-bit transfer.
REQ-011 spi_tx_data  input  8  byte to transmit.
REQ-012 spi_tx_data_vld  input  1  single-cycle strobe; loads spi_tx_data.
REQ-013 spi_rx_data  output  8  last received byte, registered.
REQ-014 spi_ready  output  1  1 = idle and accepting spi_start; 0 = transfer in progress.

Function
REQ-015 The FSM SHALL have states IDLE, SCK_LOW, SCK_HIGH and DONE, plus a bit counter (3 bits) and a half-period counter (8 bits).
REQ-016 On spi_enable_vld, spi_ss SHALL become ~spi_enable at the next edge in any state; an ongoing transfer continues unaffected.
REQ-017 In IDLE, spi_tx_data_vld SHALL load the tx shift register; it SHALL be ignored in all other states.
REQ-018 In IDLE, spi_start SHALL cause: state to SCK_LOW, spi_ready to 0, bit counter to 0, half counter to 0, spi_mosi to tx[7].
REQ-019 If spi_start and spi_tx_data_vld coincide in IDLE, the transfer SHALL use the new spi_tx_data value.
REQ-020 spi_start SHALL be ignored outside IDLE; there is no queueing.
REQ-021 SCK_LOW: after HALF_PERIOD cycles, go to SCK_HIGH, set spi_sck to 1, shift spi_miso into rx shift LSB.
REQ-022 SCK_HIGH: after HALF_PERIOD cycles, set spi_sck to 0; if bit counter is 7 go to DONE; otherwise increment the bit counter, shift tx left, drive the next bit on spi_mosi, and go to SCK_LOW.
REQ-023 DONE SHALL last one cycle: copy rx shift to spi_rx_data, set spi_ready to 1, go to IDLE.
REQ-024 spi_ready SHALL be low for exactly 16*HALF_PERIOD+1 cycles per transfer; spi_rx_data SHALL change on the same edge that spi_ready rises.
REQ-025 spi_mosi SHALL be stable whenever spi_sck is high.
REQ-026 spi_mosi SHALL hold its last value after a transfer until the next spi_start.
REQ-027 spi_rx_data SHALL hold its value until the next completed transfer.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, spi_ss 1, spi_sck 0, spi_mosi 0, spi_ready 1, spi_rx_data 0x00, and all shift registers and counters to 0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no partial update of spi_rx_data.
REQ-030 After reset, the first spi_start SHALL behave as in REQ-018.

Verification
REQ-031 HALF_PERIOD=1, spi_mosi looped to spi_miso, tx_data_vld 0xA5, then start: spi_ready low for 17 cycles, 8 SCK pulses, spi_rx_data = 0xA5.
REQ-032 spi_miso tied 1, tx 0x00: spi_mosi stays 0, spi_rx_data = 0xFF; then spi_miso tied 0, tx 0x3C: MOSI shows 0,0,1,1,1,1,0,0, spi_rx_data = 0x00.
REQ-033 spi_start and tx_data_vld 0x11 issued 5 cycles into a transfer of 0x80: both ignored; loopback spi_rx_data = 0x80; a following transfer sends 0x80 again.
REQ-034 spi_enable_vld with spi_enable=1 makes spi_ss 0 on the next edge; spi_enable=0 mid-transfer makes spi_ss 1 while SCK keeps toggling until done.
REQ-035 reset_n low at cycle 9 of a transfer: outputs take reset values immediately (asynchronously), spi_rx_data = 0x00, spi_ready = 1.
REQ-036 HALF_PERIOD=4: spi_ready low for 65 cycles; each SCK high and low phase lasts 4 cycles; loopback of 0x5A returns 0x5A.
